// File: rtl/regfile.sv
// rtl/regfile.sv - architectural register file with rename-tag table and commit bypass
module regfile #(
  parameter int ROB_WIDTH = 4,
  parameter int REG_NUM   = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 dec_ready,
  input  logic [4:0]           dec_rs1,
  input  logic [4:0]           dec_rs2,
  input  logic [4:0]           dec_rd,
  input  logic                 dec_rd_valid,
  input  logic [ROB_WIDTH-1:0] dec_rob_id,
  output logic                 op1_ready,
  output logic [31:0]          op1_val,
  output logic [ROB_WIDTH-1:0] op1_dep,
  output logic                 op2_ready,
  output logic [31:0]          op2_val,
  output logic [ROB_WIDTH-1:0] op2_dep,
  output logic [ROB_WIDTH-1:0] search_rob_id_1,
  input  logic                 search_ready_1,
  input  logic [31:0]          search_val_1,
  output logic [ROB_WIDTH-1:0] search_rob_id_2,
  input  logic                 search_ready_2,
  input  logic [31:0]          search_val_2,
  input  logic                 commit_valid,
  input  logic [ROB_WIDTH-1:0] commit_rob_id,
  input  logic [4:0]           commit_reg_id,
  input  logic [31:0]          commit_val
);

  logic [31:0]          val_q [REG_NUM];
  logic [31:0]          val_d [REG_NUM];
  logic [ROB_WIDTH-1:0] tag_q [REG_NUM];
  logic [ROB_WIDTH-1:0] tag_d [REG_NUM];
  logic [REG_NUM-1:0]   busy_q;
  logic [REG_NUM-1:0]   busy_d;

  typedef struct packed {
    logic        ready;
    logic [31:0] val;
  } operand_t;

  // Resolve one source: x0, idle register, same-cycle commit, ROB search, else wait on tag.
  function automatic operand_t resolve(input logic [4:0] rs,
                                       input logic s_ready,
                                       input logic [31:0] s_val);
    operand_t r;
    r.ready = 1'b0;
    r.val   = 32'd0;
    if (rs == 5'd0) begin
      r.ready = 1'b1;
    end else if (!busy_q[rs]) begin
      r.ready = 1'b1;
      r.val   = val_q[rs];
    end else if (commit_valid && commit_reg_id == rs && commit_rob_id == tag_q[rs]) begin
      r.ready = 1'b1;
      r.val   = commit_val;
    end else if (s_ready) begin
      r.ready = 1'b1;
      r.val   = s_val;
    end
    return r;
  endfunction

  // Combinational operand lookup on pre-edge state; lookup sees the mapping before this rename.
  always_comb begin
    operand_t o1;
    operand_t o2;
    o1 = resolve(dec_rs1, search_ready_1, search_val_1);
    o2 = resolve(dec_rs2, search_ready_2, search_val_2);
    op1_ready       = o1.ready;
    op1_val         = o1.val;
    op2_ready       = o2.ready;
    op2_val         = o2.val;
    op1_dep         = tag_q[dec_rs1];
    op2_dep         = tag_q[dec_rs2];
    search_rob_id_1 = tag_q[dec_rs1];
    search_rob_id_2 = tag_q[dec_rs2];
  end

  // Next state: commit writes value, clear wipes renames, otherwise a rename overrides the commit.
  always_comb begin
    val_d  = val_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (commit_valid && commit_reg_id != 5'd0) begin
      val_d[commit_reg_id] = commit_val;
      if (tag_q[commit_reg_id] == commit_rob_id) begin
        busy_d[commit_reg_id] = 1'b0;
      end
    end
    if (clear) begin
      busy_d = '0;
      for (int i = 0; i < REG_NUM; i++) begin
        tag_d[i] = '0;
      end
    end else if (dec_ready && dec_rd_valid && dec_rd != 5'd0) begin
      busy_d[dec_rd] = 1'b1;
      tag_d[dec_rd]  = dec_rob_id;
    end
  end

  // State registers; async reset wipes everything, rdy_in low freezes.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (rdy_in) begin
      busy_q <= busy_d;
      val_q  <= val_d;
      tag_q  <= tag_d;
    end
  end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- Architectural register file and rename-tag table for the out-of-order core.
- Sits between decoder, reservation stations / LSB, and the reorder buffer.
- Resolves source operands at issue: from the register, from the ROB search port, or by same-cycle commit bypass.
- Records the ROB tag of each in-flight destination and retires values from the ROB commit port.
- Other end of the ROB commit and search interfaces.

Parameters:
ROB_WIDTH, 4, ROB index width (ROB holds 2^ROB_WIDTH entries)
REG_NUM, 32, architectural registers; x0 hard-wired zero

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset, asynchronous, active-low
rdy_in  in  1  pause when low: all state holds
clear  in  1  mispredict flush from ROB
dec_ready  in  1  decoder issues an instruction this cycle
dec_rs1  in  5  source 1 index
dec_rs2  in  5  source 2 index
dec_rd  in  5  destination index
dec_rd_valid  in  1  instruction writes rd
dec_rob_id  in  ROB_WIDTH  ROB entry allocated to the instruction (ROB empty_rob_id)
op1_ready  out  1  source 1 value available
op1_val  out  32  source 1 value (valid when op1_ready)
op1_dep  out  ROB_WIDTH  ROB tag to wait on (valid when !op1_ready)
op2_ready, op2_val, op2_dep  out  1/32/ROB_WIDTH  same for source 2
search_rob_id_1  out  ROB_WIDTH  tag of rs1 sent to ROB search
search_ready_1  in  1  ROB entry has result
search_val_1  in  32  ROB entry result
search_rob_id_2, search_ready_2, search_val_2  out/in/in  same for rs2
commit_valid  in  1  ROB retires a register-writing entry this cycle
commit_rob_id  in  ROB_WIDTH  retiring entry
commit_reg_id  in  5  retiring destination
commit_val  in  32  retiring value

Behaviour:
- State per register r: val[r] (32), busy[r] (1), tag[r] (ROB_WIDTH).
- Reset (rst_in low, async): all val, busy and tag cleared to 0.
  - Outputs after reset: op*_ready=1, op*_val=0, op*_dep=0, search_rob_id_*=0.
- Lookup (combinational, per source s, evaluated on pre-edge state, in priority order):
  1. dec_rs==0 -> ready=1, val=0.
  2. !busy[s] -> ready=1, val=val[s].
  3. commit_valid && commit_reg_id==s && commit_rob_id==tag[s] -> ready=1, val=commit_val.
  4. search_ready_n -> ready=1, val=search_val_n.
  5. Otherwise ready=0, dep=tag[s].
- search_rob_id_n = tag[dec_rs_n], driven unconditionally.
- op*_dep = tag[s] in all cases; consumers ignore it when ready=1.
- An instruction whose rs equals its own rd sees the mapping from before its own rename.
- Sequential update at posedge, only when rdy_in=1; rdy_in=0 -> no state change.
- Commit (commit_valid, commit_reg_id!=0):
  - val[reg] <= commit_val, regardless of tag.
  - busy[reg] <= 0 only if tag[reg]==commit_rob_id (a newer rename stays busy).
- Rename (dec_ready && dec_rd_valid && dec_rd!=0 && !clear): busy[rd] <= 1, tag[rd] <= dec_rob_id.
- Same-cycle commit and rename to the same register: value is written, rename wins, so busy=1 and tag=dec_rob_id.
- clear=1: every busy <= 0, tag <= 0, and rename is suppressed. A commit in the same cycle still writes its value.
- Writes to x0 are ignored; x0 is never busy.
- No pipeline latency on lookup. Commit is visible in register state one cycle later and via bypass in the same cycle.
- Reset asserted mid-operation wipes all state immediately, independent of clock and rdy_in.

Test Plan:
- Reset, then dec_rs1=5, dec_rs2=0 -> op1_ready=1/val=0, op2_ready=1/val=0; search_rob_id_1=0.
- Rename rd=3 tag=2. Next cycle rs1=3 with search_ready_1=0 -> op1_ready=0, op1_dep=2, search_rob_id_1=2. Drive search_ready_1=1, search_val_1=0x1234 -> op1_ready=1, op1_val=0x1234.
- Same cycle as a lookup of rs1=3: commit rob_id=2 reg=3 val=0xABCD -> op1 bypass ready with 0xABCD. Next cycle busy[3]=0 and val[3]=0xABCD.
- Rename rd=7 tag=4, then rename rd=7 tag=6, then commit tag=4 val=9 -> val[7]=9 but busy, dep=6. Simultaneous commit tag=6 + rename rd=7 tag=8 -> dep=8.
- Rename rd=1 tag=1 and rd=2 tag=3, then clear=1 with dec_ready/rd=4 -> regs 1,2,4 all not busy after edge; commit in the clear cycle still updates its value.
- rdy_in=0 with commit and rename on rd=9 -> no change. Pull rst_in low mid-cycle -> all values 0 immediately. Rename/commit to rd=0 -> x0 reads 0, ready.
